// File: rtl/wb_stream_writer_fifo.sv
// Word FIFO between the Wishbone stream writer and a valid/ready sink.
// A one-word output register sits after the array, and the stream can be cut into fixed-length packets.
// Define WB_STREAM_FIFO_OVF_EN to build the sticky overflow flag.
module wb_stream_writer_fifo #(
  parameter int DW      = 32,
  parameter int FIFO_AW = 5,
  parameter int LEN_W   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [DW-1:0]      fifo_d,
  input  logic               fifo_wr,
  output logic [FIFO_AW:0]   fifo_cnt,
  input  logic               clear_i,
  input  logic [LEN_W-1:0]   pkt_len_i,
  output logic [DW-1:0]      stream_data_o,
  output logic               stream_valid_o,
  input  logic               stream_ready_i,
  output logic               stream_last_o,
  output logic               overflow_o
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   pkt_len_m1;
  logic               full;
  logic               wr_acc;
  logic               pop;
  logic               hs;

  // A full array drops the word, even if the same cycle pops a slot free.
  assign full       = (fifo_cnt == FULL_CNT);
  assign wr_acc     = fifo_wr && !full;
  assign pop        = (fifo_cnt != '0) && (!stream_valid_o || stream_ready_i);
  assign hs         = stream_valid_o && stream_ready_i;
  assign pkt_len_m1 = pkt_len_i - LEN_W'(1);

  assign stream_last_o = stream_valid_o && (pkt_len_i != '0) && (beat_cnt == pkt_len_m1);

  // NOTE: the storage array has no reset; only the pointers and the count define which words are live.
  always_ff @(posedge wb_clk_i) begin
    if (wr_acc && !clear_i)
      mem[wr_ptr] <= fifo_d;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_acc, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // The output register refills whenever it is empty or is being consumed.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stream_data_o  <= '0;
      stream_valid_o <= 1'b0;
    end else if (clear_i) begin
      stream_valid_o <= 1'b0;
    end else if (pop) begin
      stream_data_o  <= mem[rd_ptr];
      stream_valid_o <= 1'b1;
    end else if (stream_ready_i) begin
      stream_valid_o <= 1'b0;
    end
  end

  // With pkt_len_i == 0 the beat counter free-runs and wraps.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      beat_cnt <= '0;
    else if (clear_i)
      beat_cnt <= '0;
    else if (hs)
      beat_cnt <= stream_last_o ? '0 : beat_cnt + LEN_W'(1);
  end

`ifdef WB_STREAM_FIFO_OVF_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      overflow_o <= 1'b0;
    else if (clear_i)
      overflow_o <= 1'b0;
    else if (fifo_wr && full)
      overflow_o <= 1'b1;
  end
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stream_writer_fifo.sv
// Bench for wb_stream_writer_fifo: a queue-based reference model checked every cycle, plus directed scenarios.
// The bench follows WB_STREAM_FIFO_OVF_EN the same way the design does.
module tb_wb_stream_writer_fifo;
  localparam int DW = 32, FIFO_AW = 5, LEN_W = 16, DEPTH = 32;

  logic               clk = 1'b0, rst = 1'b0;
  logic [DW-1:0]      fifo_d = '0;
  logic               fifo_wr = 1'b0, clear = 1'b0, ready = 1'b0;
  logic [LEN_W-1:0]   pkt_len = '0;
  logic [FIFO_AW:0]   fifo_cnt;
  logic [DW-1:0]      sdata;
  logic               svalid, slast, ovf;

  wb_stream_writer_fifo #(.DW(DW), .FIFO_AW(FIFO_AW), .LEN_W(LEN_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt),
    .clear_i(clear), .pkt_len_i(pkt_len), .stream_data_o(sdata), .stream_valid_o(svalid),
    .stream_ready_i(ready), .stream_last_o(slast), .overflow_o(ovf));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: array contents as a queue, plus the output word, beat count and overflow flag.
  logic [DW-1:0]    q[$];
  logic [DW-1:0]    m_data, head;
  logic             m_valid, m_ovf;
  logic [LEN_W-1:0] m_beat;
  bit               m_full, m_pop, m_hs, m_was_last;

  function automatic bit model_last();
    logic [LEN_W-1:0] pm1;
    pm1 = pkt_len - LEN_W'(1);
    return m_valid && (pkt_len != 0) && (m_beat == pm1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_valid = 0; m_data = '0; m_beat = '0; m_ovf = 0;
    end else if (clear) begin
      q.delete(); m_valid = 0; m_beat = '0; m_ovf = 0;
    end else begin
      m_full     = (q.size() == DEPTH);
      m_was_last = model_last();
      m_hs       = m_valid && ready;
      m_pop      = (q.size() != 0) && (!m_valid || ready);
      head       = '0;
      if (m_pop) head = q.pop_front();
      if (fifo_wr) begin
        if (m_full) begin
`ifdef WB_STREAM_FIFO_OVF_EN
          m_ovf = 1;
`endif
        end else q.push_back(fifo_d);
      end
      if (m_hs) m_beat = m_was_last ? '0 : m_beat + LEN_W'(1);
      if (m_pop) begin m_data = head; m_valid = 1; end
      else if (ready) m_valid = 0;
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("cnt",   64'(fifo_cnt), 64'(q.size()));
      check("valid", 64'(svalid),   64'(m_valid));
      check("last",  64'(slast),    64'(model_last()));
      check("ovf",   64'(ovf),      64'(m_ovf));
      if (m_valid) check("data", 64'(sdata), 64'(m_data));
    end
  end

  // Records every accepted beat.
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  always @(negedge clk) begin
    if (!rst && svalid && ready) begin
      got_d.push_back(sdata);
      got_l.push_back(slast);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  logic [DW-1:0] exp_d[$];
  logic [DW-1:0] held;
  bit            stalled;

  initial begin
    #1 rst = 1;
    #12 rst = 0;
    tick();
    check("rst_valid", 64'(svalid), 64'(0));
    check("rst_data",  64'(sdata),  64'(0));
    check("rst_cnt",   64'(fifo_cnt), 64'(0));
    check("rst_last",  64'(slast),  64'(0));
    check("rst_ovf",   64'(ovf),    64'(0));

    // Single word, sink ready.
    ready = 1; fifo_d = 32'hA5A5_0001; fifo_wr = 1; tick(); fifo_wr = 0;
    check("t1_cnt_k",   64'(fifo_cnt), 64'(1));
    check("t1_valid_k", 64'(svalid),   64'(0));
    tick();
    check("t1_cnt_k1",   64'(fifo_cnt), 64'(0));
    check("t1_valid_k1", 64'(svalid),   64'(1));
    check("t1_data_k1",  64'(sdata),    64'h0000_0000_A5A5_0001);
    tick();
    check("t1_valid_k2", 64'(svalid),   64'(0));

    // Fill with the sink stalled, then overflow by one word.
    ready = 0;
    for (int i = 0; i < 32; i++) begin fifo_d = DW'(i); fifo_wr = 1; tick(); end
    fifo_wr = 0;
    check("t2_cnt31", 64'(fifo_cnt), 64'(31));
    check("t2_head",  64'(sdata),    64'(0));
    fifo_d = 32'hDEAD; fifo_wr = 1; tick();
    check("t2_cnt32", 64'(fifo_cnt), 64'(32));
    fifo_d = 32'hBEEF; tick(); fifo_wr = 0;
    check("t2_cnt_drop", 64'(fifo_cnt), 64'(32));
`ifdef WB_STREAM_FIFO_OVF_EN
    check("t2_ovf", 64'(ovf), 64'(1));
`else
    check("t2_ovf", 64'(ovf), 64'(0));
`endif
    ready = 1;
    for (int i = 0; i < 33; i++) begin
      check("t2_stream_valid", 64'(svalid), 64'(1));
      check("t2_stream_data",  64'(sdata),  (i < 32) ? 64'(i) : 64'h0000_DEAD);
      tick();
    end
    check("t2_drained", 64'(svalid), 64'(0));
    do_clear();

    // Packets of 4, ten words, sink always ready.
    pkt_len = 4; got_d.delete(); got_l.delete(); exp_d.delete();
    for (int i = 0; i < 10; i++) begin
      fifo_d = $urandom; exp_d.push_back(fifo_d); fifo_wr = 1; tick();
    end
    fifo_wr = 0;
    repeat (5) tick();
    check("t3_count", 64'(got_d.size()), 64'(10));
    for (int i = 0; i < 10 && i < got_d.size(); i++) begin
      check("t3_data", 64'(got_d[i]), 64'(exp_d[i]));
      check("t3_last", 64'(got_l[i]), 64'(i == 3 || i == 7));
    end
    check("t3_beat_dut",   64'(dut.beat_cnt), 64'(2));
    check("t3_beat_model", 64'(m_beat),       64'(2));
    do_clear();

    // Packets of 3, sink toggling every cycle.
    pkt_len = 3; got_d.delete(); got_l.delete(); exp_d.delete();
    stalled = 0; held = '0;
    for (int c = 0; c < 24; c++) begin
      if (stalled && svalid) check("t4_stall_hold", 64'(sdata), 64'(held));
      if (c < 6) begin fifo_d = $urandom; exp_d.push_back(fifo_d); fifo_wr = 1; end
      else fifo_wr = 0;
      ready   = (c % 2 == 0);
      stalled = svalid && !ready;
      held    = sdata;
      tick();
    end
    ready = 1; repeat (4) tick();
    check("t4_count", 64'(got_d.size()), 64'(6));
    for (int i = 0; i < 6 && i < got_d.size(); i++) begin
      check("t4_data", 64'(got_d[i]), 64'(exp_d[i]));
      check("t4_last", 64'(got_l[i]), 64'(i == 2 || i == 5));
    end
    do_clear();

    // Clear in the middle of a stream, together with a write.
    pkt_len = 0; ready = 0;
    for (int i = 0; i < 13; i++) begin fifo_d = $urandom; fifo_wr = 1; tick(); end
    check("t5_cnt12", 64'(fifo_cnt), 64'(12));
    check("t5_valid", 64'(svalid),   64'(1));
    clear = 1; fifo_d = 32'h1234; tick(); clear = 0; fifo_wr = 0;
    check("t5_clr_cnt",   64'(fifo_cnt), 64'(0));
    check("t5_clr_valid", 64'(svalid),   64'(0));
    check("t5_clr_ovf",   64'(ovf),      64'(0));
    ready = 1; fifo_d = 32'hC0FF_EE01; fifo_wr = 1; tick(); fifo_wr = 0;
    check("t5_cnt1", 64'(fifo_cnt), 64'(1));
    tick();
    check("t5_first_valid", 64'(svalid), 64'(1));
    check("t5_first_data",  64'(sdata),  64'h0000_0000_C0FF_EE01);
    check("t5_first_beat",  64'(dut.beat_cnt), 64'(0));
    tick();

    // Asynchronous reset between clock edges while streaming.
    for (int i = 0; i < 6; i++) begin fifo_d = $urandom; fifo_wr = 1; tick(); end
    check("t6_pre_valid", 64'(svalid), 64'(1));
    #2 rst = 1;
    #1;
    check("t6_async_valid", 64'(svalid),   64'(0));
    check("t6_async_cnt",   64'(fifo_cnt), 64'(0));
    fifo_wr = 0;
    @(posedge clk); #1 rst = 0;
    tick();

    // Random traffic against the model, with phases that fill the array.
    pkt_len = 5;
    for (int c = 0; c < 3000; c++) begin
      fifo_wr = ($urandom_range(0, 99) < 70);
      fifo_d  = $urandom;
      ready   = (c < 1000) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 75);
      clear   = ($urandom_range(0, 199) == 0);
      tick();
    end
    fifo_wr = 0; clear = 0; ready = 1;
    repeat (40) tick();
    check("end_empty_cnt",   64'(fifo_cnt), 64'(0));
    check("end_empty_valid", 64'(svalid),   64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stream_writer_fifo.md
Name: wb_stream_writer_fifo

Overview:
- Downstream stage of the Wishbone stream writer controller.
- Buffers words read over Wishbone (fifo_d/fifo_wr) in a 2**FIFO_AW-deep synchronous FIFO.
- Reports the storage occupancy (fifo_cnt) back to the controller for burst admission.
- Emits the data as a valid/ready stream with optional fixed-length packet framing (stream_last_o).

Parameters:
DW, 32, data width of FIFO words and stream output
FIFO_AW, 5, FIFO address width; storage depth = 2**FIFO_AW words
LEN_W, 16, width of packet length input

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
fifo_d  in  DW  write data from writer controller
fifo_wr  in  1  write strobe, one word per cycle
fifo_cnt  out  FIFO_AW+1  words held in storage array (0..2**FIFO_AW), excluding output register
clear_i  in  1  synchronous flush
pkt_len_i  in  LEN_W  words per packet; 0 = unframed
stream_data_o  out  DW  output data
stream_valid_o  out  1  output data valid
stream_ready_i  in  1  sink ready
stream_last_o  out  1  final word of packet
overflow_o  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release on wb_clk_i): wr_ptr=rd_ptr=0, fifo_cnt=0, stream_valid_o=0, stream_data_o=0, stream_last_o=0, beat_cnt=0, overflow_o=0.
- Storage: dual-pointer RAM, pointers FIFO_AW bits, wrap modulo 2**FIFO_AW. fifo_cnt is a registered counter: +1 on accepted write, -1 on pop, unchanged when both or neither occur.
- Write: fifo_wr accepted when fifo_cnt < 2**FIFO_AW at that edge. At fifo_cnt == 2**FIFO_AW the word is dropped: pointer and count unchanged, even if a pop occurs in the same cycle.
- Output register (one word):
  - Pop from array when fifo_cnt != 0 and (stream_valid_o==0 or stream_ready_i==1).
  - On pop: stream_data_o <= RAM[rd_ptr], stream_valid_o <= 1, rd_ptr+1.
  - On handshake with no pop: stream_valid_o <= 0.
- Latency: fifo_wr sampled at edge k into an empty block → stream_valid_o high after edge k+1. Sustained throughput 1 word/clock when ready is held high.
- stream_data_o and stream_valid_o hold stable while valid && !ready.
- Framing:
  - beat_cnt (LEN_W bits) increments on each handshake (valid && ready). It resets to 0 after the handshake of a last word.
  - stream_last_o = stream_valid_o && pkt_len_i != 0 && beat_cnt == pkt_len_i-1; combinational from registers.
  - pkt_len_i == 0: stream_last_o never asserted; beat_cnt still counts and wraps naturally.
  - pkt_len_i is changed by software only while stream_valid_o==0 and fifo_cnt==0.
- clear_i (synchronous, priority over all other activity): pointers, fifo_cnt, beat_cnt, stream_valid_o, overflow_o → 0. A fifo_wr in the same cycle is discarded.
- Reset mid-stream: all state returns to reset values immediately; no partial packet completion.

Optional Feature:
- Macro WB_STREAM_FIFO_OVF_EN.
- Defined: overflow_o set on any dropped write (fifo_wr while fifo_cnt == 2**FIFO_AW). It is sticky until clear_i or reset.
- Undefined: no overflow logic; overflow_o tied to 0. All other behaviour is identical.

Test Plan:
- Reset, then one write of 0xA5A5_0001 with ready=1 → fifo_cnt 1 after write edge, 0 after next edge; stream_valid_o high with data 0xA5A5_0001 from edge k+1 for exactly one cycle.
- ready=0, write 32 words 0..31 (FIFO_AW=5), then write 0xDEAD → word 0 sits in the output register; fifo_cnt reaches 31. Write 33 (0xDEAD) is accepted as the 32nd array word; one further write is dropped, fifo_cnt stays 32, and overflow_o=1 when the macro is defined, else 0. Release ready → words 0..31 and 0xDEAD stream out in order, no gaps.
- pkt_len_i=4, 10 words, ready=1 → stream_last_o on words 3 and 7 only; beat_cnt=2 at end.
- pkt_len_i=3, ready toggling 1010… during 6 words → data stable while stalled; last on words 2 and 5; no duplicate or lost words.
- Mid-stream clear_i with fifo_cnt=12 and valid=1, asserted together with fifo_wr → next cycle fifo_cnt=0, valid=0, overflow_o=0; subsequent write appears after two edges as first word with beat_cnt=0.
- Async wb_rst_i asserted between clock edges while streaming → stream_valid_o and fifo_cnt drop to 0 before the next edge.
